// File: rtl/tia_multiphase_clock.sv
// N-phase, non-overlapping one-hot phase clock generator derived from a single master clock.
// The default parameters reproduce the legacy TIA biphase sequence: phi2, gap, phi1, gap.
module tia_multiphase_clock #(
  parameter int PHASES      = 2,
  parameter int HIGH_CYCLES = 1,
  parameter int GAP_CYCLES  = 1,
  localparam int IW = ($clog2(PHASES) > 1) ? $clog2(PHASES) : 1
) (
  input  logic              clk,
  input  logic              r,
  input  logic              en,
  output logic [PHASES-1:0] phi,
  output logic              rl,
  output logic [IW-1:0]     phase_idx,
  output logic              wrap
);

  localparam int CMAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW   = ($clog2(CMAX) > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] HI_LAST  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] TOP_IDX  = IW'(PHASES - 1);

  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_HI  = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PHASES-1:0] phi_q, phi_d;
  logic              rl_q, rl_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic [IW-1:0]     next_idx_s;

  function automatic logic [PHASES-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(PHASES-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign next_idx_s = (idx_q == {IW{1'b0}}) ? TOP_IDX : (idx_q - IW'(1));

  // Next-state logic: reset beats everything, en=0 freezes all state and silences wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    rl_d    = rl_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (r) begin
      state_d = ST_RST;
      cnt_d   = {CW{1'b0}};
      phi_d   = {PHASES{1'b0}};
      rl_d    = 1'b1;
      idx_d   = TOP_IDX;
    end else if (en) begin
      case (state_q)
        ST_RST: begin
          state_d = ST_HI;
          cnt_d   = {CW{1'b0}};
          rl_d    = 1'b0;
          idx_d   = TOP_IDX;
          phi_d   = onehot(TOP_IDX);
        end
        ST_HI: begin
          if (cnt_q == HI_LAST) begin
            state_d = ST_GAP;
            cnt_d   = {CW{1'b0}};
            phi_d   = {PHASES{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_HI;
            cnt_d   = {CW{1'b0}};
            idx_d   = next_idx_s;
            phi_d   = onehot(next_idx_s);
            // Leaving phase 0's gap starts a new full rotation.
            wrap_d  = (idx_q == {IW{1'b0}});
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_RST;
          cnt_d   = {CW{1'b0}};
          phi_d   = {PHASES{1'b0}};
          rl_d    = 1'b1;
          idx_d   = TOP_IDX;
        end
      endcase
    end else begin
      wrap_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    phi_q   <= phi_d;
    rl_q    <= rl_d;
    idx_q   <= idx_d;
    wrap_q  <= wrap_d;
  end

  assign phi       = phi_q;
  assign rl        = rl_q;
  assign phase_idx = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_tia_multiphase_clock.sv
// Scoreboard bench: three configurations (2/1/1, 4/3/2, 8/2/1) driven side by side and
// compared every negedge against a rotation-position reference model.
module tb_tia_multiphase_clock;

  logic       clk = 1'b0;
  logic [2:0] r_v = 3'b111;
  logic [2:0] en_v = 3'b000;

  logic [1:0] phi0; logic rl0; logic [0:0] idx0; logic wrap0;
  logic [3:0] phi1; logic rl1; logic [1:0] idx1; logic wrap1;
  logic [7:0] phi2; logic rl2; logic [2:0] idx2; logic wrap2;

  int n_checks = 0;
  int n_errors = 0;

  int  pp [3];
  int  hh [3];
  int  gg [3];
  bit  started [3];
  int  tpos [3];
  bit  wflag [3];

  logic [12:0] exp_q0 [$];
  logic [12:0] exp_q1 [$];
  logic [12:0] exp_q2 [$];
  logic [12:0] act0, act1, act2;

  always #5 clk = ~clk;

  tia_multiphase_clock #(.PHASES(2), .HIGH_CYCLES(1), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .r(r_v[0]), .en(en_v[0]), .phi(phi0), .rl(rl0), .phase_idx(idx0), .wrap(wrap0));
  tia_multiphase_clock #(.PHASES(4), .HIGH_CYCLES(3), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .r(r_v[1]), .en(en_v[1]), .phi(phi1), .rl(rl1), .phase_idx(idx1), .wrap(wrap1));
  tia_multiphase_clock #(.PHASES(8), .HIGH_CYCLES(2), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .r(r_v[2]), .en(en_v[2]), .phi(phi2), .rl(rl2), .phase_idx(idx2), .wrap(wrap2));

  assign act0 = {wrap0, rl0, 3'(idx0), 8'(phi0)};
  assign act1 = {wrap1, rl1, 3'(idx1), 8'(phi1)};
  assign act2 = {wrap2, rl2, 3'(idx2), 8'(phi2)};

  // Expected {wrap, rl, idx, phi} from position t within the rotation.
  function automatic logic [12:0] expect_word(input int i);
    int per, slot, off, idx;
    logic [7:0] ph;
    if (!started[i]) return {1'b0, 1'b1, 3'(pp[i] - 1), 8'h00};
    per  = hh[i] + gg[i];
    slot = tpos[i] / per;
    off  = tpos[i] % per;
    idx  = pp[i] - 1 - slot;
    ph   = (off < hh[i]) ? (8'h01 << idx) : 8'h00;
    return {wflag[i], 1'b0, 3'(idx), ph};
  endfunction

  task automatic drive(input logic [2:0] rv, input logic [2:0] ev);
    @(negedge clk);
    #1;
    r_v  = rv;
    en_v = ev;
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) begin
        started[i] = 1'b0; tpos[i] = 0; wflag[i] = 1'b0;
      end else if (ev[i]) begin
        if (!started[i]) begin
          started[i] = 1'b1; tpos[i] = 0; wflag[i] = 1'b0;
        end else begin
          tpos[i]  = (tpos[i] + 1) % (pp[i] * (hh[i] + gg[i]));
          wflag[i] = (tpos[i] == 0);
        end
      end else begin
        wflag[i] = 1'b0;
      end
    end
    exp_q0.push_back(expect_word(0));
    exp_q1.push_back(expect_word(1));
    exp_q2.push_back(expect_word(2));
  endtask

  task automatic cmp(input string name, input logic [12:0] exp_w, input logic [12:0] act_w);
    n_checks++;
    if (act_w !== exp_w) begin
      n_errors++;
      $display("FAIL %s at %0t: got wrap=%b rl=%b idx=%0d phi=%b, expected wrap=%b rl=%b idx=%0d phi=%b",
               name, $time, act_w[12], act_w[11], act_w[10:8], act_w[7:0],
               exp_w[12], exp_w[11], exp_w[10:8], exp_w[7:0]);
    end
  endtask

  task automatic onehot_chk(input string name, input logic [7:0] ph);
    n_checks++;
    if ($countones(ph) > 1) begin
      n_errors++;
      $display("FAIL %s at %0t: phi=%b has %0d bits set, expected at most 1", name, $time, ph, $countones(ph));
    end
  endtask

  // Monitor: pop one expectation per configuration at every negedge once stimulus has begun.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        cmp("cfg211", exp_q0.pop_front(), act0);
        onehot_chk("onehot211", act0[7:0]);
      end
      if (exp_q1.size() > 0) begin
        cmp("cfg432", exp_q1.pop_front(), act1);
        onehot_chk("onehot432", act1[7:0]);
      end
      if (exp_q2.size() > 0) begin
        cmp("cfg821", exp_q2.pop_front(), act2);
        onehot_chk("onehot821", act2[7:0]);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomised en/r traffic.
  initial begin
    pp = '{2, 4, 8};
    hh = '{1, 3, 2};
    gg = '{1, 2, 1};
    for (int i = 0; i < 3; i++) begin
      started[i] = 1'b0; tpos[i] = 0; wflag[i] = 1'b0;
    end

    // Reset for two clocks, then free-running rotations.
    drive(3'b111, 3'b000);
    drive(3'b111, 3'b000);
    for (int k = 0; k < 45; k++) drive(3'b000, 3'b111);

    // Stall cfg 4/3/2 in the middle of phase 2's high window.
    drive(3'b111, 3'b111);
    for (int k = 0; k < 6; k++) drive(3'b000, 3'b111);
    for (int k = 0; k < 5; k++) drive(3'b000, 3'b101);
    for (int k = 0; k < 45; k++) drive(3'b000, 3'b111);

    // Single-cycle reset during a gap, then during a high window.
    for (int k = 0; k < 4; k++) drive(3'b000, 3'b111);
    drive(3'b111, 3'b111);
    for (int k = 0; k < 7; k++) drive(3'b000, 3'b111);
    drive(3'b111, 3'b111);
    for (int k = 0; k < 25; k++) drive(3'b000, 3'b111);

    // Hold in reset: r low but en low for four clocks.
    drive(3'b111, 3'b111);
    for (int k = 0; k < 4; k++) drive(3'b000, 3'b000);
    for (int k = 0; k < 10; k++) drive(3'b000, 3'b111);

    // Reset together with en low: reset must still win.
    drive(3'b111, 3'b000);
    for (int k = 0; k < 5; k++) drive(3'b000, 3'b111);

    // Randomised en/r traffic on all configurations.
    for (int k = 0; k < 1000; k++) begin
      logic [2:0] rv, ev;
      for (int i = 0; i < 3; i++) begin
        rv[i] = ($urandom_range(0, 59) == 0);
        ev[i] = ($urandom_range(0, 3) != 0);
      end
      drive(rv, ev);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tia_multiphase_clock.md
# tia_multiphase_clock

Parametrised successor to the TIA biphase clock generator. Derives an N-phase, non-overlapping, one-hot phase clock set from the single master clock, with programmable high and gap widths per phase. Adds a stall enable, a current-phase index and a once-per-cycle wrap strobe, so downstream TIA logic can run on more than two phases and can be frozen for single-step debug. The default parameters reproduce the legacy biphase sequence exactly.

## Interface

- PHASES, 2, number of output phases; legal range 2..8.
- HIGH_CYCLES, 1, master clocks each phase is held high; ≥1.
- GAP_CYCLES, 1, master clocks of all-zero gap after each phase; ≥1. This gap guarantees non-overlap.
- clk  input  1  master clock; all state changes on posedge.
- r  input  1  reset; synchronous, active-high.
- en  input  1  advance enable; 0 freezes all state and outputs.
- phi  output  PHASES  phase outputs; at most one bit set.
- rl  output  1  reset-latched flag; 1 until the sequence starts.
- phase_idx  output  IW  index of the current or most recent phase. IW = max(1, $clog2(PHASES)).
- wrap  output  1  one-cycle strobe at the start of each new full rotation.

## Operation

- All outputs are registered and change only after a posedge of clk.
- FSM states:
  - RST: phi=0, rl=1.
  - HI: phi[phase_idx]=1, rl=0.
  - GAP: phi=0, rl=0.
- Cycle counter cnt is wide enough for max(HIGH_CYCLES, GAP_CYCLES)-1. It clears on every state change.
- Reset: at any posedge with r=1, the block enters RST with phi=0, rl=1, phase_idx=PHASES-1, cnt=0 and wrap=0. r has priority over en and over every other transition. These are also the reset values of all outputs.
- RST → HI: at the first posedge with r=0 and en=1. At that edge:
  - rl goes to 0.
  - phi[PHASES-1] goes to 1.
  - wrap stays 0 for this first entry.
  - While en=0 the block remains in RST with rl=1.
- HI with en=1: cnt increments each clock. At the edge where cnt==HIGH_CYCLES-1, the block moves to GAP and phi goes to 0.
- GAP with en=1: at the edge where cnt==GAP_CYCLES-1, the block moves to HI with phase_idx = (phase_idx==0) ? PHASES-1 : phase_idx-1, and phi takes the one-hot of the new index.
- Phase order is descending and wraps: PHASES-1, PHASES-2, …, 0, PHASES-1, …. For PHASES=2 this gives phi2, gap, phi1, gap, which is the legacy order.
- wrap is 1 for exactly the first HI cycle of phase PHASES-1 after phase 0's gap. It is never asserted on the entry from RST, and it is 0 in every other cycle.
- en=0 in HI or GAP: phi, phase_idx, cnt, state and rl all hold. wrap is forced to 0 while en=0. A strobe that was due is emitted on the first enabled cycle that completes the transition.
- Invariant: popcount(phi) ≤ 1 at every cycle, including across reset and stall.

## Timing

- Latency from r deassert to phi[PHASES-1]=1 is one posedge, provided en=1 on that edge.
- Each phase is high for exactly HIGH_CYCLES enabled clocks, followed by GAP_CYCLES enabled clocks of all-zero.
- Full rotation period is PHASES × (HIGH_CYCLES + GAP_CYCLES) enabled clocks.
- With en held at 1, there are exactly PHASES × (HIGH_CYCLES + GAP_CYCLES) clocks between successive wrap pulses.
- Outputs are stable from shortly after posedge through the following negedge. Benches sample on negedge.
- Reset mid-operation, in any state or count: phi is 0 and rl is 1 on the cycle after the edge where r was sampled high. No partial phase or glitch is allowed.
- Simultaneous r=1 and en=0: reset wins.
- Simultaneous end-of-HI and en falling: en is sampled at the same edge, so no transition occurs.

## Test plan

- Defaults (2/1/1), r=1 for 2 clocks then 0, en=1. Negedge samples must read:
  - (phi, rl) = (00, 1) during reset,
  - then (10, 0), (00, 0), (01, 0), (00, 0), (10, 0), …
  - wrap=1 only at the second (10).
- PHASES=4, HIGH=3, GAP=2, en=1. Each phi bit is high 3 clocks, in order 8→4→2→1, separated by 2 all-zero clocks. wrap pulses every 20 clocks. phase_idx tracks 3, 2, 1, 0.
- Stall: in the PHASES=4 config, drop en for 5 clocks in the middle of phase 2's high window. phi=0100 and phase_idx=2 hold through the stall, and the phase then completes its remaining high clocks. There is no wrap during the stall, and the wrap period extends by exactly 5.
- Reset mid-rotation: assert r for 1 clock during a GAP and during a HI.
  - The next sample must be phi=0, rl=1, phase_idx=PHASES-1.
  - Restart must begin at phi[PHASES-1], with wrap=0 on that entry.
- Hold in reset: r=0 but en=0 for 4 clocks after reset. rl stays 1 and phi stays 0. The first en=1 edge gives phi[PHASES-1]=1 and rl=0.
- Overlap checker across 1000 randomised en/r cycles for PHASES=8, HIGH=2, GAP=1. popcount(phi) ≤ 1 always, and wrap never coincides with en=0.
